// File: rtl/seq_divider.sv
// seq_divider: 8-bit by 4-bit unsigned restoring divider, one quotient bit per cycle.
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic [3:0] rem;
  logic [7:0] q;
  logic [4:0] rem_sh;
  logic [3:0] rem_nxt;
  logic       ge;
  // Partial remainder always ends below 16, so only the shifted value needs the fifth bit.
  assign rem_sh  = {rem, dvd[7]};
  assign ge      = rem_sh >= {1'b0, dvs};
  assign rem_nxt = ge ? 4'(rem_sh - {1'b0, dvs}) : rem_sh[3:0];
  assign busy    = state == CALC;
  assign done    = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = divisor == 4'd0 ? DONE : CALC;
    else if (state == CALC && cnt == 4'd1) state_nxt = DONE;
    else if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      q           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && start) begin
      dvd <= dividend;
      dvs <= divisor;
      rem <= '0;
      q   <= '0;
      cnt <= 4'd8;
      if (divisor == 4'd0) begin
        quotient    <= 8'hFF;
        remainder   <= 4'hF;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      rem <= rem_nxt;
      q   <= {q[6:0], ge};
      dvd <= {dvd[6:0], 1'b0};
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        quotient    <= {q[6:0], ge};
        remainder   <= rem_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule
